// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: accepts one register-to-register command at a time,
// reads two operands from a 16 x 8 register file, computes an ALU result
// with zero/carry flags, and writes the result back (CMP skips the write).
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE. The source must hold cmd_* stable until
// that transfer; cmd_valid while busy is not consumed.
module reg_op_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  output logic [ADDR_W-1:0] RA1,
  output logic [ADDR_W-1:0] RA2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic [ADDR_W-1:0] WA,
  output logic [DATA_W-1:0] wr_data,
  output logic              write_enable,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  logic [1:0]        state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic [DATA_W:0]   ext;

  // Outputs decoded from state only; nothing combinational from cmd_*.
  assign cmd_ready    = (state == IDLE);
  assign done         = (state == WRITE);
  assign write_enable = (state == WRITE) && (op_q != OP_CMP);
  assign state_dbg    = state;

  // ALU on the captured operands; carry is the 9th bit (borrow for SUB/CMP).
  always_comb begin
    ext       = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        ext       = {1'b0, a_q} + {1'b0, b_q};
        alu_res   = ext[DATA_W-1:0];
        alu_carry = ext[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        ext       = {1'b0, a_q} - {1'b0, b_q};
        alu_res   = ext[DATA_W-1:0];
        alu_carry = ext[DATA_W];
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_MOV: alu_res = a_q;
      OP_SHL: begin
        alu_res   = {a_q[DATA_W-2:0], 1'b0};
        alu_carry = a_q[DATA_W-1];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with command latch, operand capture and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      op_q       <= OP_ADD;
      rd_q       <= '0;
      RA1        <= '0;
      RA2        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      WA         <= '0;
      wr_data    <= '0;
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            RA1   <= cmd_rs1;
            RA2   <= cmd_rs2;
            state <= READ;
          end
        end
        READ: begin
          a_q   <= rf_data1;
          b_q   <= rf_data2;
          state <= EXEC;
        end
        EXEC: begin
          result     <= alu_res;
          flag_zero  <= (alu_res == '0);
          flag_carry <= alu_carry;
          WA         <= rd_q;
          wr_data    <= alu_res;
          state      <= WRITE;
        end
        default: begin
          // WRITE: the register file commits on this edge.
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench for reg_op_sequencer with a behavioural 16 x 8 register file.
module tb_reg_op_sequencer;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_rs1, cmd_rs2, cmd_rd;
  logic [3:0] RA1, RA2, WA;
  logic [7:0] rf_data1, rf_data2, wr_data, result;
  logic       write_enable, done, flag_zero, flag_carry;
  logic [1:0] state_dbg;

  int tests_run = 0;
  int failed    = 0;
  int cyc       = 0;
  int we_count  = 0;

  // Register file model plus a bench-side preload port.
  logic [7:0] rf [16];
  logic       tb_we;
  logic [3:0] tb_wa;
  logic [7:0] tb_wd;

  assign rf_data1 = rf[RA1];
  assign rf_data2 = rf[RA2];

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file write port and cycle/write-pulse counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tb_we) begin
      rf[tb_wa] <= tb_wd;
    end else if (write_enable) begin
      rf[WA]   <= wr_data;
      we_count <= we_count + 1;
    end
  end

  reg_op_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .RA1(RA1), .RA2(RA2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .WA(WA), .wr_data(wr_data), .write_enable(write_enable), .done(done),
    .result(result), .flag_zero(flag_zero), .flag_carry(flag_carry),
    .state_dbg(state_dbg)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [3:0] addr, input logic [7:0] data);
    tb_we = 1'b1;
    tb_wa = addr;
    tb_wd = data;
    tick;
    tb_we = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      tick;
      n++;
    end
    check({tag, "_ready"}, cmd_ready, 1);
  endtask

  // Present a command, wait for ready, pass the accepting edge E0.
  task automatic issue(input string tag, input logic [2:0] op, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic [3:0] rd);
    cmd_op    = op;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_rd    = rd;
    cmd_valid = 1'b1;
    wait_ready(tag);
    tick;
    cmd_valid = 1'b0;
  endtask

  // From just after E0: walk E1..E3 and check the write-cycle outputs.
  task automatic finish_cmd(input string tag, input logic exp_we, input logic [3:0] exp_wa,
                            input logic [7:0] exp_res, input logic exp_z, input logic exp_c);
    tick;
    check({tag, "_exec_done"}, done, 0);
    tick;
    check({tag, "_done"}, done, 1);
    check({tag, "_we"}, write_enable, exp_we);
    check({tag, "_wa"}, WA, exp_wa);
    check({tag, "_wr_data"}, wr_data, exp_res);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, flag_zero, exp_z);
    check({tag, "_carry"}, flag_carry, exp_c);
    tick;
    check({tag, "_done_drop"}, done, 0);
    check({tag, "_we_drop"}, write_enable, 0);
    check({tag, "_ready_back"}, cmd_ready, 1);
  endtask

  initial begin
    int t0;
    int t1;
    int we_before;

    reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_rs1   = 4'd1;
    cmd_rs2   = 4'd2;
    cmd_rd    = 4'd3;
    tb_we     = 1'b0;
    tb_wa     = 4'd0;
    tb_wd     = 8'd0;

    // Reset held for two edges with a command pending.
    tick;
    tick;
    check("rst_ready", cmd_ready, 1);
    check("rst_we", write_enable, 0);
    check("rst_done", done, 0);
    check("rst_state", state_dbg, 0);
    check("rst_ra1", RA1, 0);
    check("rst_ra2", RA2, 0);
    check("rst_wa", WA, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_result", result, 0);
    check("rst_zero", flag_zero, 0);
    check("rst_carry", flag_carry, 0);
    cmd_valid = 1'b0;
    reset     = 1'b1;
    tick;
    check("post_rst_state", state_dbg, 0);
    check("post_rst_ready", cmd_ready, 1);

    for (int i = 0; i < 16; i++) poke(i[3:0], 8'd0);
    poke(4'd1, 8'd5);
    poke(4'd2, 8'd7);
    poke(4'd5, 8'd200);
    poke(4'd6, 8'd100);

    // ADD r3 = r1 + r2 = 12.
    issue("add", 3'd0, 4'd1, 4'd2, 4'd3);
    check("add_ra1", RA1, 1);
    check("add_ra2", RA2, 2);
    check("add_busy", cmd_ready, 0);
    check("add_state_read", state_dbg, 1);
    finish_cmd("add", 1'b1, 4'd3, 8'd12, 1'b0, 1'b0);
    check("add_rf3", rf[3], 12);

    // ADD overflow 200 + 100 = 44, carry.
    issue("add_ovf", 3'd0, 4'd5, 4'd6, 4'd7);
    finish_cmd("add_ovf", 1'b1, 4'd7, 8'd44, 1'b0, 1'b1);
    check("add_ovf_rf7", rf[7], 44);

    // SUB 5 - 7 = 254, borrow.
    issue("sub_borrow", 3'd1, 4'd1, 4'd2, 4'd8);
    finish_cmd("sub_borrow", 1'b1, 4'd8, 8'd254, 1'b0, 1'b1);

    // SUB 7 - 7 = 0 with rs1 == rs2.
    issue("sub_zero", 3'd1, 4'd2, 4'd2, 4'd9);
    finish_cmd("sub_zero", 1'b1, 4'd9, 8'd0, 1'b1, 1'b0);

    // SHL 200 (0xC8) -> 0x90 = 144, carry out of bit 7.
    issue("shl", 3'd6, 4'd5, 4'd0, 4'd11);
    finish_cmd("shl", 1'b1, 4'd11, 8'd144, 1'b0, 1'b1);

    // XOR 5 ^ 7 = 2, rd equal to a source register.
    issue("xor", 3'd4, 4'd1, 4'd2, 4'd1);
    finish_cmd("xor", 1'b1, 4'd1, 8'd2, 1'b0, 1'b0);
    check("xor_rf1", rf[1], 2);
    poke(4'd1, 8'd5);

    // CMP 9 vs 9: flags update, no write-back.
    poke(4'd10, 8'd9);
    poke(4'd4, 8'd33);
    we_before = we_count;
    issue("cmp", 3'd7, 4'd10, 4'd10, 4'd4);
    finish_cmd("cmp", 1'b0, 4'd4, 8'd0, 1'b1, 1'b0);
    check("cmp_rf4", rf[4], 33);
    check("cmp_no_pulse", we_count - we_before, 0);

    // Back-to-back dependent commands with cmd_valid held high.
    poke(4'd3, 8'd0);
    poke(4'd4, 8'd0);
    cmd_op    = 3'd0;
    cmd_rs1   = 4'd1;
    cmd_rs2   = 4'd2;
    cmd_rd    = 4'd3;
    cmd_valid = 1'b1;
    wait_ready("b2b_first");
    tick;
    t0 = cyc;
    cmd_rs1 = 4'd3;
    cmd_rs2 = 4'd3;
    cmd_rd  = 4'd4;
    wait_ready("b2b_second");
    tick;
    t1 = cyc;
    cmd_valid = 1'b0;
    check("b2b_spacing", t1 - t0, 4);
    finish_cmd("b2b", 1'b1, 4'd4, 8'd24, 1'b0, 1'b0);
    check("b2b_rf3", rf[3], 12);
    check("b2b_rf4", rf[4], 24);

    // Reset during EXEC aborts the write.
    poke(4'd6, 8'd99);
    we_before = we_count;
    issue("abort", 3'd0, 4'd1, 4'd2, 4'd6);
    tick;
    check("abort_in_exec", state_dbg, 2);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    check("abort_we", write_enable, 0);
    check("abort_done", done, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_state", state_dbg, 0);
    tick;
    tick;
    tick;
    check("abort_no_pulse", we_count - we_before, 0);
    check("abort_rf6", rf[6], 99);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
